// File: rtl/imm_pkg.sv
// Shared immediate-format constants for the encoder and the immediate extender.
package imm_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  localparam int unsigned ImmW = 32;
  localparam int unsigned OutW = 25;

endpackage

// File: rtl/imm_pack.sv
// Combinational packing of an immediate into instruction bits [31:7], plus range check.
// Range check is present only when IMM_RANGE_CHECK_EN is defined.
module imm_pack
  import imm_pkg::*;
(
  input  logic [1:0]      src,
  input  logic [ImmW-1:0] imm,
  output logic [OutW-1:0] word,
  output logic            err
);

  // word[k] is instruction bit k+7
  always_comb begin
    word = '0;
    unique case (src)
      IMM_I: word[24:13] = imm[11:0];
      IMM_S: begin
        word[24:18] = imm[11:5];
        word[4:0]   = imm[4:0];
      end
      IMM_B: begin
        word[24]    = imm[12];
        word[23:18] = imm[10:5];
        word[4:1]   = imm[4:1];
        word[0]     = imm[11];
      end
      IMM_J: begin
        word[24]    = imm[20];
        word[23:14] = imm[10:1];
        word[13]    = imm[11];
        word[12:5]  = imm[19:12];
      end
      default: word = '0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  always_comb begin
    err = 1'b0;
    unique case (src)
      IMM_I, IMM_S: err = imm[31:12] != {20{imm[11]}};
      IMM_B:        err = (imm[31:13] != {19{imm[12]}}) || imm[0];
      IMM_J:        err = (imm[31:21] != {11{imm[20]}}) || imm[0];
      default:      err = 1'b0;
    endcase
  end
`else
  logic unused_imm;
  assign unused_imm = ^imm[31:21];
  assign err        = 1'b0;
`endif

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: packs requests via imm_pack and queues results in a small FIFO.
// Define IMM_RANGE_CHECK_EN to enable range_err and the saturating err_count.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned ERRW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ImmSrc,
  input  logic [ImmW-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OutW-1:0] out,
  output logic            range_err,
  output logic [ERRW-1:0] err_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [OutW-1:0] pack_word;
  logic            pack_err;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic [OutW-1:0] word_mem_q [DEPTH];
  logic            push, pop;

  imm_pack u_pack (
    .src  (ImmSrc),
    .imm  (imm),
    .word (pack_word),
    .err  (pack_err)
  );

  // Both handshakes drop during reset so nothing is accepted or consumed on a reset edge.
  assign in_ready  = (count_q != FullCount) && !reset;
  assign out_valid = (count_q != '0) && !reset;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out       = out_valid ? word_mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) word_mem_q[wr_ptr_q] <= pack_word;
  end

`ifdef IMM_RANGE_CHECK_EN
  logic            err_mem_q [DEPTH];
  logic [ERRW-1:0] err_count_q;

  always_ff @(posedge clk) begin
    if (push) err_mem_q[wr_ptr_q] <= pack_err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= '0;
    end else if (push && pack_err && !(&err_count_q)) begin
      err_count_q <= err_count_q + ERRW'(1);
    end
  end

  assign range_err = out_valid && err_mem_q[rd_ptr_q];
  assign err_count = err_count_q;
`else
  logic unused_err;
  assign unused_err = pack_err;
  assign range_err  = 1'b0;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: queue model checked every cycle plus literal checks.
module tb_imm_encoder;

  localparam int DEPTH = 2;
  localparam int ERRW  = 8;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ImmSrc;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out;
  logic        range_err;
  logic [7:0]  err_count;

  imm_encoder #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ImmSrc    (ImmSrc),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .range_err (range_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding from the field layout, using plain shifts and masks on the value.
  function automatic logic [24:0] enc(input logic [1:0] f, input logic [31:0] v);
    logic [31:0] r;
    case (f)
      2'd0:    r = (v & 32'hFFF) << 13;
      2'd1:    r = (((v >> 5) & 32'h7F) << 18) | (v & 32'h1F);
      2'd2:    r = (((v >> 12) & 32'd1) << 24) | (((v >> 5) & 32'h3F) << 18)
                 | (v & 32'h1E) | ((v >> 11) & 32'd1);
      default: r = (((v >> 20) & 32'd1) << 24) | (((v >> 1) & 32'h3FF) << 14)
                 | (((v >> 11) & 32'd1) << 13) | (((v >> 12) & 32'hFF) << 5);
    endcase
    return r[24:0];
  endfunction

  function automatic bit oor(input logic [1:0] f, input logic [31:0] v);
    int s;
    s = int'(v);
    case (f)
      2'd0, 2'd1: return (s < -2048) || (s > 2047);
      2'd2:       return (s < -4096) || (s > 4095) || v[0];
      default:    return (s < -(1 << 20)) || (s >= (1 << 20)) || v[0];
    endcase
  endfunction

  // Immediate extender as it would decode a full instruction.
  function automatic logic [31:0] extend(input logic [1:0] f, input logic [24:0] o);
    logic [31:0] ins;
    ins = {o, 7'b0};
    case (f)
      2'd0:    return {{20{ins[31]}}, ins[31:20]};
      2'd1:    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      2'd2:    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      default: return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endcase
  endfunction

  typedef struct {
    logic [1:0]  fmt;
    logic [31:0] val;
    logic [24:0] w;
    bit          rng;
  } ent_t;

  ent_t q[$];
  int   m_errcnt = 0;

  always @(negedge clk) begin
    bit   ev, er;
    ent_t e;
    if (chk_en) begin
      ev = !reset && (q.size() > 0);
      er = !reset && (q.size() < DEPTH);
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("out", 32'(out), ev ? 32'(q[0].w) : 32'd0);
      chk("range_err", 32'(range_err), ev ? 32'(RC && q[0].rng) : 32'd0);
      chk("err_count", 32'(err_count), 32'(m_errcnt));
      if (reset) begin
        q.delete();
        m_errcnt = 0;
      end else begin
        if (ev && out_ready) begin
          if (!q[0].rng) chk("roundtrip", extend(q[0].fmt, out), q[0].val);
          void'(q.pop_front());
        end
        if (er && in_valid) begin
          e.fmt = ImmSrc;
          e.val = imm;
          e.w   = enc(ImmSrc, imm);
          e.rng = oor(ImmSrc, imm);
          q.push_back(e);
          if (RC && e.rng && m_errcnt < 255) m_errcnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [1:0] f, input logic [31:0] v);
    ImmSrc   = f;
    imm      = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int s;
    reset = 1'b1; in_valid = 1'b0; ImmSrc = 2'd0; imm = 32'd0; out_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    chk("lit_rst_in_ready", 32'(in_ready), 32'd0);
    chk("lit_rst_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("lit_post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("lit_post_rst_err_count", 32'(err_count), 32'd0);

    // I-format, sign-extended negative boundary value
    push1(2'd0, 32'hFFFFF800);
    chk("lit_i_valid", 32'(out_valid), 32'd1);
    chk("lit_i_out", 32'(out), 32'h1000000);
    chk("lit_i_err", 32'(range_err), 32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // B-format: odd value is out of range, then an in-range negative value
    push1(2'd2, 32'h00001001);
    chk("lit_b_err", 32'(range_err), 32'(RC));
    chk("lit_b_errcnt", 32'(err_count), 32'(RC));
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    push1(2'd2, 32'hFFFFFFFE);
    chk("lit_b_out", 32'(out), 32'h1FC001F);
    chk("lit_b_err2", 32'(range_err), 32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Backpressure: three S pushes into a two-entry FIFO, then full-with-pop edge
    ImmSrc = 2'd1; in_valid = 1'b1;
    imm = 32'h00000005; tick();
    imm = 32'h000007FF; tick();
    chk("lit_full_in_ready", 32'(in_ready), 32'd0);
    imm = 32'hFFFFF800; tick(); tick();
    chk("lit_held_in_ready", 32'(in_ready), 32'd0);
    chk("lit_held_head", 32'(out), 32'h0000005);
    out_ready = 1'b1; tick();
    chk("lit_nopush_head", 32'(out), 32'h0FC001F);
    chk("lit_nopush_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("lit_third_head", 32'(out), 32'h1000000);
    tick();
    chk("lit_drained", 32'(out_valid), 32'd0);

    // Round-trip of random in-range values, four formats
    in_valid = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 1000; i++) begin
        ImmSrc = 2'(f);
        case (f)
          0, 1:    s = int'($urandom_range(0, 4095)) - 2048;
          2:       s = (int'($urandom_range(0, 8191)) - 4096) & ~1;
          default: s = (int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20)) & ~1;
        endcase
        imm = 32'(s);
        tick();
      end
    end
    in_valid = 1'b0;
    tick(); tick();

    // Out-of-range stream saturating the counter, then reset mid-stream
    in_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      ImmSrc = 2'(i % 4);
      imm    = 32'h00100001 + 32'(i);
      tick();
    end
    chk("lit_sat_errcnt", 32'(err_count), RC ? 32'd255 : 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("lit_mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("lit_mid_rst_errcnt", 32'(err_count), 32'd0);
    chk("lit_mid_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("lit_after_rst_push", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter DEPTH, 2, output buffer entries (power of two, >=2).
REQ-002 SHALL have parameter ERRW, 8, width of err_count.
REQ-003 SHALL have clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have in_valid, input, 1, request carries a valid immediate.
REQ-006 SHALL have in_ready, output, 1, block accepts a request this cycle.
REQ-007 SHALL have ImmSrc, input, 2, format: 00 I, 01 S, 10 B, 11 J.
REQ-008 SHALL have imm, input, 32, signed immediate value to encode.
REQ-009 SHALL have out_valid, output, 1, head entry valid.
REQ-010 SHALL have out_ready, input, 1, consumer takes head entry.
REQ-011 SHALL have out, output, 25, instruction bits [31:7]; non-immediate fields zero.
REQ-012 SHALL have range_err, output, 1, head entry's imm not representable in its format.
REQ-013 SHALL have err_count, output, ERRW, saturating count of accepted out-of-range requests.

Function
REQ-014 SHALL map out[k] to instruction bit k+7.
REQ-015 SHALL encode I: out[24:13]=imm[11:0]; all other bits 0.
REQ-016 SHALL encode S: out[24:18]=imm[11:5], out[4:0]=imm[4:0]; others 0.
REQ-017 SHALL encode B: out[24]=imm[12], out[23:18]=imm[10:5], out[4:1]=imm[4:1], out[0]=imm[11]; others 0.
REQ-018 SHALL encode J: out[24]=imm[20], out[23:14]=imm[10:1], out[13]=imm[11], out[12:5]=imm[19:12]; others 0.
REQ-019 SHALL flag range error: I/S if imm[31:12] not all equal imm[11]; B if imm[31:13] not all equal imm[12] or imm[0]=1; J if imm[31:21] not all equal imm[20] or imm[0]=1.
REQ-020 SHALL still encode out-of-range requests by truncation, with range_err=1 on that entry.
REQ-021 SHALL accept a request on an edge where in_valid and in_ready are both 1.
REQ-022 SHALL store encoded word and range_err in a DEPTH-entry FIFO, in acceptance order.
REQ-023 SHALL drive in_ready = not full; no bypass when full, even if out_ready=1.
REQ-024 SHALL make an entry accepted at edge N visible (out_valid=1) from after edge N; latency 1 cycle.
REQ-025 SHALL pop head on an edge where out_valid and out_ready are both 1.
REQ-026 SHALL support simultaneous push and pop when not full and not empty; occupancy unchanged.
REQ-027 SHALL hold out, range_err stable while out_valid=1 and out_ready=0.
REQ-028 SHALL drive out=0, range_err=0 when empty.
REQ-029 SHALL wrap read/write pointers modulo DEPTH.
REQ-030 SHALL increment err_count on acceptance of an out-of-range request; hold at all-ones.

Reset
REQ-031 SHALL, on reset, empty the FIFO, zero pointers and err_count; out_valid=0, in_ready=0 during reset cycle, 1 thereafter.
REQ-032 SHALL discard in-flight entries and ignore in_valid on a reset edge mid-operation.

Configuration
REQ-033 SHALL honour macro IMM_RANGE_CHECK_EN: defined -> REQ-019/030 active; undefined -> range_err and err_count tied 0, no check logic, encoding unchanged.

Structure
REQ-034 SHALL place ImmSrc constants (IMM_I, IMM_S, IMM_B, IMM_J) in shared package imm_pkg, reused by the extender.
REQ-035 SHALL implement packing and range check in combinational sub-module imm_pack; FIFO and counter in imm_encoder.

Verification
REQ-036 I, imm=0xFFFFF800 -> out=0x1000000 (out[24:13]=0x800), range_err=0, one cycle after accept.
REQ-037 B, imm=0x00001001 -> range_err=1, err_count 0->1; B, imm=0xFFFFFFFE -> out=0x1FC001F, range_err=0.
REQ-038 Round-trip: 1000 random in-range imm per format through imm_encoder then extend -> extend output equals imm.
REQ-039 out_ready=0, push 3 -> in_ready=0 after 2 accepts; third held; release -> order preserved, values unchanged.
REQ-040 Stream 256+ out-of-range requests -> err_count saturates at 255; reset mid-stream -> out_valid=0, err_count=0 next cycle.
REQ-041 Full FIFO with in_valid=1 and out_ready=1 -> pop occurs, no push that edge; push on next edge.
